data_bus_responder: RTL and testbench
=====================================

# data_bus_responder

Multi-cycle responder on the processor's data-memory bus. Accepts one load/store request at a time over a valid/ready handshake and answers after a fixed number of wait states. Requests are decoded to a word-addressed RAM or to three memory-mapped registers: a free-running cycle counter, a transmit FIFO push port and a FIFO status word. It sits between the processor's memory port and the on-chip RAM/peripheral side, and its transmit FIFO drains to an external consumer.

## Interface
Parameters:
- DEPTH_WORDS, 256: RAM size in 32-bit words; power of two.
- WAIT_STATES, 2: extra cycles between request accept and response; 0..15.
- FIFO_DEPTH, 8: transmit FIFO entries; power of two, at least 2.

Ports:
- CLK  in  1  the only clock; all logic updates on its rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on the rising edge of CLK.
- req_valid  in  1  request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_ready  out  1  responder can accept a request this cycle.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load data; 0 for stores and for errors.
- resp_err  out  1  misaligned, unmapped, read-only violation, or FIFO overflow.
- tx_data  out  32  FIFO head.
- tx_valid  out  1  FIFO not empty.
- tx_ready  in  1  consumer pops the head when tx_valid and tx_ready are both 1.

## Operation
- Address map (addr[1:0] must be 00):
  - 0x0000_0000 to DEPTH_WORDS*4-1: RAM, read/write.
  - 0xFFFF_0000: CYCLES, read-only.
  - 0xFFFF_0004: TX_DATA, write-only; a store pushes into the FIFO.
  - 0xFFFF_0008: TX_STATUS, read-only; bits [15:0] = FIFO occupancy, bit 31 = full.
- Error cases:
  - Any other address, or addr[1:0] nonzero, sets resp_err=1 and has no side effect.
  - A store to CYCLES or TX_STATUS, or a load from TX_DATA, sets resp_err=1.
- State machine:
  - IDLE: req_ready=1. When req_valid=1, capture write/addr/wdata and go to WAIT, or go directly to RESP if WAIT_STATES=0.
  - WAIT: a 4-bit counter loaded with WAIT_STATES counts down. Move to RESP when the counter reaches 1. req_ready=0.
  - RESP: resp_valid=1 for exactly one cycle. Store side effects commit in this cycle. Always returns to IDLE. req_ready=0.
- Loads: resp_rdata carries the value as it stands in the RESP cycle. RAM reads return the word at addr[log2(DEPTH_WORDS)+1:2]. CYCLES returns the counter value in the RESP cycle.
- CYCLES: 32-bit counter, +1 every cycle while out of reset, wraps 0xFFFF_FFFF to 0.
- FIFO push: a TX_DATA store in RESP pushes req_wdata if occupancy < FIFO_DEPTH, or if a pop happens in the same cycle.
- FIFO overflow: if the FIFO is full and no pop happens in the same cycle, the data is dropped and resp_err=1.
- FIFO pop is independent of the request FSM. Simultaneous push and pop leaves occupancy unchanged.

## Timing
- Reset (RESET=0 at an edge) forces:
  - state IDLE;
  - req_ready=0 during reset, then 1 in the first cycle after reset is released;
  - resp_valid=0, resp_rdata=0, resp_err=0;
  - CYCLES=0;
  - FIFO empty, tx_valid=0, tx_data=0.
  - RAM contents are not reset.
- Reset during WAIT aborts the transaction: no RAM write, no FIFO push, no response.
- Latency: a request is accepted at edge N (IDLE, req_valid=1). resp_valid is high in cycle N+WAIT_STATES+1.
- Throughput: one transaction per WAIT_STATES+2 cycles.
- req_* inputs are ignored outside IDLE. The requester holds req_valid until it sees req_ready=1.
- tx_data and tx_valid are registered. A pushed word is visible at the head on the cycle after the push.

## Test plan
- Reset then idle: RESET=0 for 3 cycles, then 1. Require req_ready=1, tx_valid=0 and resp_valid=0 in the first cycle after release, and CYCLES read 0 cycles later returns a value matching the cycle count.
- RAM round trip, WAIT_STATES=2: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010. Require resp_valid exactly 3 cycles after each accept, resp_rdata=0xDEADBEEF, resp_err=0.
- Errors: load 0x0000_0013, store to 0xFFFF_0000, load 0x1000_0000. Each must give resp_err=1 and resp_rdata=0; RAM is unchanged.
- FIFO: with tx_ready=0, push 9 words 0x1..0x9. Require TX_STATUS=0x8000_0008 after 8 pushes, resp_err=1 on the 9th push, then tx_ready=1 drains 0x1..0x8 in order.
- Full FIFO with simultaneous pop: fill to 8, then push 0xA in the same cycle as a pop. Require resp_err=0, occupancy stays 8, and 0xA is the last word out.
- Reset mid-WAIT: with WAIT_STATES=4, store 0x55 to 0x0000_0020 and assert reset 2 cycles later. Require no resp_valid; a later load of 0x0000_0020 returns the prior contents.

Source files
------------

// File: rtl/data_bus_responder.sv
`default_nettype none
// =============================================================================
// data_bus_responder : multi-cycle data-bus slave with RAM, cycle counter and
//                      transmit FIFO behind a valid/ready request handshake.
// Revision: 1.0
// =============================================================================
module data_bus_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam int          FW          = $clog2(FIFO_DEPTH);
  localparam logic [31:0] ADDR_CYCLES = 32'hFFFF_0000;
  localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0004;
  localparam logic [31:0] ADDR_TXSTAT = 32'hFFFF_0008;
  localparam logic [3:0]  WAIT_LOAD   = 4'(WAIT_STATES);
  localparam logic [FW:0] FIFO_FULL   = (FW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [3:0]  wait_cnt_next;

  logic        cur_write;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  logic [31:0] cycles;
  logic [31:0] ram [DEPTH_WORDS];

  logic [31:0] fifo_mem [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr;
  logic [FW-1:0] wr_ptr;
  logic [FW-1:0] rd_ptr_next;
  logic [FW:0]   count;
  logic [FW:0]   count_next;
  logic [31:0]   head_next;

  logic        in_resp;
  logic        word_aligned;
  logic        hit_ram;
  logic        hit_cycles;
  logic        hit_txd;
  logic        hit_txs;
  logic        access_err;
  logic        fifo_full;
  logic        pop;
  logic        push;
  logic        overflow;
  logic        ram_we;
  logic [AW-1:0] ram_idx;
  logic [31:0] status_word;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      cur_write <= 1'b0;
      cur_addr  <= 32'd0;
      cur_wdata <= 32'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == ST_IDLE && req_valid) begin
        cur_write <= req_write;
        cur_addr  <= req_addr;
        cur_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    req_ready     = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = RESET;
        if (req_valid) begin
          wait_cnt_next = WAIT_LOAD;
          state_next    = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Leaving on a count of 1 gives exactly WAIT_STATES cycles in WAIT.
        if (wait_cnt <= 4'd1) begin
          state_next = ST_RESP;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address decode and response
  // ---------------------------------------------------------------------------
  assign in_resp      = (state == ST_RESP);
  assign word_aligned = (cur_addr[1:0] == 2'b00);
  assign hit_ram      = word_aligned && ((cur_addr >> (AW + 2)) == 32'd0);
  assign hit_cycles   = (cur_addr == ADDR_CYCLES);
  assign hit_txd      = (cur_addr == ADDR_TXDATA);
  assign hit_txs      = (cur_addr == ADDR_TXSTAT);
  assign ram_idx      = cur_addr[AW+1:2];

  assign access_err = !(hit_ram || hit_cycles || hit_txd || hit_txs)
                   || (cur_write && (hit_cycles || hit_txs))
                   || (!cur_write && hit_txd);

  assign fifo_full   = (count == FIFO_FULL);
  assign pop         = tx_valid && tx_ready;
  assign overflow    = cur_write && hit_txd && fifo_full && !pop;
  assign push        = in_resp && cur_write && hit_txd && (!fifo_full || pop);
  assign ram_we      = in_resp && cur_write && hit_ram;
  assign status_word = {fifo_full, 15'd0, 16'(count)};

  assign resp_valid = in_resp;
  assign resp_err   = in_resp && (access_err || overflow);

  always_comb begin
    resp_rdata = 32'd0;
    if (in_resp && !cur_write && !access_err) begin
      if (hit_ram) begin
        resp_rdata = ram[ram_idx];
      end else if (hit_cycles) begin
        resp_rdata = cycles;
      end else if (hit_txs) begin
        resp_rdata = status_word;
      end
    end
  end

  // RAM contents survive reset; the RESET term blocks a commit on a reset edge.
  always_ff @(posedge CLK) begin
    if (RESET && ram_we) begin
      ram[ram_idx] <= cur_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cycles <= 32'd0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FIFO with registered head
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_ptr_next = pop ? rd_ptr + FW'(1) : rd_ptr;
    count_next  = count;
    case ({push, pop})
      2'b10:   count_next = count + (FW+1)'(1);
      2'b01:   count_next = count - (FW+1)'(1);
      default: count_next = count;
    endcase
    // The next head may be the word being written this very cycle.
    if (push && (wr_ptr == rd_ptr_next)) begin
      head_next = cur_wdata;
    end else begin
      head_next = fifo_mem[rd_ptr_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && push) begin
      fifo_mem[wr_ptr] <= cur_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 32'd0;
    end else begin
      rd_ptr   <= rd_ptr_next;
      count    <= count_next;
      if (push) begin
        wr_ptr <= wr_ptr + FW'(1);
      end
      tx_valid <= (count_next != '0);
      tx_data  <= (count_next != '0) ? head_next : 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// =============================================================================
// tb_data_bus_responder : directed self-checking bench for data_bus_responder.
// Revision: 1.0
// =============================================================================
module tb_data_bus_responder;

  logic        CLK;
  logic        RESET;
  logic        req_valid, req_write, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] tx_data;
  logic        tx_valid, tx_ready;

  logic        b_req_valid, b_req_write, b_req_ready;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;
  logic [31:0] b_tx_data;
  logic        b_tx_valid, b_tx_ready;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rd;
  logic        er;
  int          lt;

  data_bus_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .FIFO_DEPTH(8)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  data_bus_responder #(.DEPTH_WORDS(256), .WAIT_STATES(4), .FIFO_DEPTH(8)) u_dut4 (
    .CLK(CLK), .RESET(RESET),
    .req_valid(b_req_valid), .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_ready(b_req_ready),
    .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Runs one transaction on DUT u (0: 2 wait states, 1: 4 wait states).
  // Called just after a falling edge; returns just after the falling edge
  // following the response. lat counts cycles from accept to response.
  task automatic xfer(input bit u, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit pop_in_resp,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n = 0;
    if (!u) begin
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    end else begin
      b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata;
    end
    while (!(u ? b_req_ready : req_ready) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (!(u ? b_req_ready : req_ready)) check("accept_timeout", 32'd0, 32'd1);
    @(negedge CLK);
    req_valid   = 1'b0;
    b_req_valid = 1'b0;
    lat = 1;
    while (!(u ? b_resp_valid : resp_valid) && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    if (pop_in_resp) begin
      tx_ready = 1'b1;
      #1;
    end
    if (!(u ? b_resp_valid : resp_valid)) check("resp_timeout", 32'd0, 32'd1);
    rdata = u ? b_resp_rdata : resp_rdata;
    err   = u ? b_resp_err : resp_err;
    @(negedge CLK);
    if (pop_in_resp) tx_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_q [8];
    int seen;

    RESET = 1'b0; tx_ready = 1'b0; b_tx_ready = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;

    // Reset held for three edges
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    check("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);
    check("rel_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rel_resp_valid", {31'd0, resp_valid}, 32'd0);

    // Counter is 1 at accept (one edge since release), 4 in the response cycle
    xfer(0, 1'b0, 32'hFFFF_0000, 32'd0, 0, rd, er, lt);
    check("cycles_read", rd, 32'd4);
    check("cycles_err", {31'd0, er}, 32'd0);

    // RAM round trip
    xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, rd, er, lt);
    check("st_lat", lt, 32'd3);
    check("st_err", {31'd0, er}, 32'd0);
    check("st_rdata", rd, 32'd0);
    xfer(0, 1'b0, 32'h0000_0010, 32'd0, 0, rd, er, lt);
    check("ld_lat", lt, 32'd3);
    check("ld_data", rd, 32'hDEAD_BEEF);
    check("ld_err", {31'd0, er}, 32'd0);

    // RAM boundaries: last word valid, first address past the end unmapped
    xfer(0, 1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 0, rd, er, lt);
    xfer(0, 1'b1, 32'h0000_0000, 32'hCAFE_0000, 0, rd, er, lt);
    xfer(0, 1'b0, 32'h0000_03FC, 32'd0, 0, rd, er, lt);
    check("ram_top", rd, 32'h0BAD_F00D);
    xfer(0, 1'b1, 32'h0000_0400, 32'h7777_7777, 0, rd, er, lt);
    check("ram_past_end_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 32'h0000_0000, 32'd0, 0, rd, er, lt);
    check("ram_word0_kept", rd, 32'hCAFE_0000);

    // Error cases
    xfer(0, 1'b0, 32'h0000_0013, 32'd0, 0, rd, er, lt);
    check("misal_ld_err", {31'd0, er}, 32'd1);
    check("misal_ld_rdata", rd, 32'd0);
    xfer(0, 1'b1, 32'h0000_0013, 32'h1111_1111, 0, rd, er, lt);
    check("misal_st_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b1, 32'hFFFF_0000, 32'h2222_2222, 0, rd, er, lt);
    check("ro_cycles_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b1, 32'hFFFF_0008, 32'h3333_3333, 0, rd, er, lt);
    check("ro_status_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 32'hFFFF_0004, 32'd0, 0, rd, er, lt);
    check("wo_txdata_err", {31'd0, er}, 32'd1);
    xfer(0, 1'b0, 32'h1000_0000, 32'd0, 0, rd, er, lt);
    check("unmapped_err", {31'd0, er}, 32'd1);
    check("unmapped_rdata", rd, 32'd0);
    xfer(0, 1'b0, 32'h0000_0010, 32'd0, 0, rd, er, lt);
    check("ram_unchanged", rd, 32'hDEAD_BEEF);
    check("fifo_no_push", {31'd0, tx_valid}, 32'd0);

    // FIFO fill, overflow and in-order drain
    for (int i = 1; i <= 8; i++) begin
      xfer(0, 1'b1, 32'hFFFF_0004, i, 0, rd, er, lt);
      check("push_err", {31'd0, er}, 32'd0);
      if (i == 3) begin
        xfer(0, 1'b0, 32'hFFFF_0008, 32'd0, 0, rd, er, lt);
        check("status_3", rd, 32'h0000_0003);
      end
    end
    check("head_valid", {31'd0, tx_valid}, 32'd1);
    check("head_data", tx_data, 32'd1);
    xfer(0, 1'b0, 32'hFFFF_0008, 32'd0, 0, rd, er, lt);
    check("status_full", rd, 32'h8000_0008);
    xfer(0, 1'b1, 32'hFFFF_0004, 32'd9, 0, rd, er, lt);
    check("overflow_err", {31'd0, er}, 32'd1);
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("drain_valid", {31'd0, tx_valid}, 32'd1);
      check("drain_data", tx_data, i);
      @(negedge CLK);
    end
    tx_ready = 1'b0;
    check("drained_valid", {31'd0, tx_valid}, 32'd0);
    check("drained_data", tx_data, 32'd0);
    xfer(0, 1'b0, 32'hFFFF_0008, 32'd0, 0, rd, er, lt);
    check("status_empty", rd, 32'd0);

    // Full FIFO with a pop in the push cycle
    for (int i = 0; i < 8; i++) xfer(0, 1'b1, 32'hFFFF_0004, 32'h11 + i, 0, rd, er, lt);
    xfer(0, 1'b1, 32'hFFFF_0004, 32'h0000_000A, 1, rd, er, lt);
    check("push_pop_err", {31'd0, er}, 32'd0);
    xfer(0, 1'b0, 32'hFFFF_0008, 32'd0, 0, rd, er, lt);
    check("push_pop_status", rd, 32'h8000_0008);
    exp_q = '{32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h18, 32'h0A};
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("pp_drain", tx_data, exp_q[i]);
      @(negedge CLK);
    end
    tx_ready = 1'b0;
    check("pp_empty", {31'd0, tx_valid}, 32'd0);

    // Reset during WAIT on the 4-wait-state instance
    xfer(1, 1'b1, 32'h0000_0020, 32'h0000_1234, 0, rd, er, lt);
    check("b_st_lat", lt, 32'd5);
    check("b_st_err", {31'd0, er}, 32'd0);
    check("b_ready", {31'd0, b_req_ready}, 32'd1);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h20; b_req_wdata = 32'h55;
    @(negedge CLK);
    b_req_valid = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (b_resp_valid) seen++;
      if (i == 1) RESET = 1'b1;
    end
    check("abort_no_resp", seen, 32'd0);
    check("b_tx_idle", {31'd0, b_tx_valid}, 32'd0);
    check("b_tx_data", b_tx_data, 32'd0);
    xfer(1, 1'b0, 32'h0000_0020, 32'd0, 0, rd, er, lt);
    check("abort_ram_kept", rd, 32'h0000_1234);
    check("b_ld_lat", lt, 32'd5);
    xfer(0, 1'b0, 32'h0000_0010, 32'd0, 0, rd, er, lt);
    check("ram_survives_rst", rd, 32'hDEAD_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
